// File: rtl/ram64_arbiter.sv
// ram64_arbiter: two-port lockable arbiter for ram_64kb; RAM64_ARB_RR_EN enables round-robin in IDLE
module ram64_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic        a_lock,
  input  logic [15:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic        b_lock,
  input  logic [15:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [7:0]  b_rdata,
  output logic [15:0] ram_address,
  output logic [7:0]  ram_data_in,
  output logic        ram_we,
  input  logic [7:0]  ram_data_out
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  state_t state, state_n;
  logic last_b;
  logic a_win;
`ifdef RAM64_ARB_RR_EN
  assign a_win = a_req && (!b_req || last_b);
`else
  assign a_win = a_req;
`endif
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
      a_gnt = state == IDLE ? a_win : state == OWN_A && a_req;
      b_gnt = state == IDLE ? b_req && !a_win : state == OWN_B && b_req;
    end
    ram_address = a_gnt ? a_addr : b_gnt ? b_addr : 16'h0000;
    ram_data_in = a_gnt ? a_wdata : b_gnt ? b_wdata : 8'h00;
    ram_we      = a_gnt ? a_we : b_gnt && b_we;
    state_n     = a_gnt ? (a_lock ? OWN_A : IDLE) : b_gnt ? (b_lock ? OWN_B : IDLE) : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= 8'h00;
      b_rdata  <= 8'h00;
    end else begin
      state    <= state_n;
      last_b   <= b_gnt ? 1'b1 : a_gnt ? 1'b0 : last_b;
      a_rvalid <= a_gnt && !a_we;
      b_rvalid <= b_gnt && !b_we;
      if (a_gnt && !a_we) a_rdata <= ram_data_out;
      if (b_gnt && !b_we) b_rdata <= ram_data_out;
    end
  end
endmodule

// File: doc/ram64_arbiter.md
# ram64_arbiter

Two-port arbiter and access sequencer for the 64 KB single-port byte RAM (`ram_64kb`). It shares that RAM between requester A (CPU side) and requester B (DMA/loader side). Each cycle it grants at most one request and drives the RAM address, data and write-enable from the winner. It registers read data back to the requester that issued the read. A per-port lock lets one requester hold the RAM across several cycles for atomic read-modify-write sequences.

## Interface
- No parameters; widths are fixed by the RAM: 16-bit address, 8-bit data.
- `clk` in 1: single clock, shared with the RAM.
- `reset` in 1: synchronous, active-high.
- `a_req` in 1: port A access request.
- `a_we` in 1: port A write (1) or read (0).
- `a_lock` in 1: port A requests to keep ownership after this access.
- `a_addr` in 16: port A byte address.
- `a_wdata` in 8: port A write data.
- `a_gnt` out 1: port A access accepted this cycle (combinational).
- `a_rvalid` out 1: port A read data valid (registered, one-cycle pulse).
- `a_rdata` out 8: port A read data.
- `b_req`, `b_we`, `b_lock`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same as port A, for port B.
- `ram_address` out 16: to RAM `address`.
- `ram_data_in` out 8: to RAM `data_in`.
- `ram_we` out 1: to RAM `we`.
- `ram_data_out` in 8: from RAM `data_out` (asynchronous read).

## Operation
- FSM states:
  - IDLE: no owner. Arbitrate between `a_req` and `b_req`.
  - OWN_A: only A may be granted; B's gnt is held 0.
  - OWN_B: the mirror of OWN_A.
- Transitions:
  - From IDLE, a granted access with its lock=1 moves to OWN_x.
  - In OWN_x, a granted access with lock=0 returns to IDLE.
  - In OWN_x with `x_req`=0, the state stays OWN_x; the owner keeps the RAM until it issues an unlocked access.
- Arbitration in IDLE:
  - With the macro defined, round-robin: the port not granted last wins on conflict.
  - A single requester is always granted.
  - The last-grant pointer updates on every grant, including grants made in OWN_x.
- RAM drive:
  - When a port is granted, `ram_address`, `ram_data_in` and `ram_we` equal that port's addr, wdata and we.
  - With no grant, `ram_we`=0, `ram_address`=0 and `ram_data_in`=0.
- Writes: commit at the clk edge that ends the grant cycle. No response is produced.
- Reads:
  - `ram_data_out` is sampled at the edge ending the grant cycle into `x_rdata`.
  - `x_rvalid`=1 in the following cycle only.
  - `x_rdata` holds its value until the next read to that port.
- Same-address write then read by the same or the other port in the next cycle: the read returns the new value.

## Timing
- Grant: combinational, same cycle as req. Requesters hold req, addr, wdata, we and lock stable until they see gnt.
- Read latency: 1 cycle from gnt to rvalid.
- Throughput: one access per cycle, back-to-back, across both ports.
- Reset values:
  - `a_rvalid` = `b_rvalid` = 0 and `a_rdata` = `b_rdata` = 0x00.
  - State IDLE; last-grant pointer = B, so A wins the first conflict.
  - `a_gnt` and `b_gnt` are 0 while `reset`=1.
  - `ram_we` = 0 while `reset`=1.
- Reset mid-operation:
  - Any ownership is dropped.
  - A pending rvalid is cleared at that edge.
  - A write presented in the reset cycle is not committed, because `ram_we` is forced 0.
- Simultaneous events:
  - Conflicting requests in IDLE: exactly one gnt.
  - Lock and gnt in the same cycle: the transition happens at that cycle's edge.
- Address wrap: none. The full 0x0000–0xFFFF range is valid.

## Configuration
- `RAM64_ARB_RR_EN`
  - Defined: round-robin arbitration in IDLE, using the last-grant pointer.
  - Undefined: fixed priority, A always beats B in IDLE. The pointer is still maintained but unused.
  - Lock ownership behaves the same either way.

## Test plan
- Reset, then A writes 0x5A to 0x1234, then A reads 0x1234: `a_gnt` is high in both cycles, `a_rvalid` is high in cycle 3 with `a_rdata`=0x5A, and `b_rvalid` stays 0.
- Both ports request continuously; A reads 0x0001 and B reads 0x0002, with prior contents 0x11 and 0x22.
  - With `RAM64_ARB_RR_EN`: grants go A, B, A, B, and the responses are 0x11, 0x22, alternating.
  - Without the macro: A is granted every cycle and B never is.
- A locked sequence:
  - A reads 0xFFFF with lock=1 while `b_req`=1 throughout; `b_gnt` stays 0.
  - A then writes 0x7F to 0xFFFF with lock=0, after an idle cycle with `a_req`=0.
  - `b_gnt` is 0 across all these cycles and first rises the cycle after the unlocked write.
  - A B read of 0xFFFF then returns 0x7F.
- `reset` is asserted in the same cycle as an A write of 0xAA to 0x0000 (memory previously held 0x33):
  - `ram_we`=0 in that cycle.
  - A later read of 0x0000 returns 0x33.
  - The state returns to IDLE.
- `reset` is asserted the cycle after a B read gnt: `b_rvalid` is 0 in the next cycle.
- B writes 0x01 to 0x8000, and A reads 0x8000 in the next cycle: `a_rdata`=0x01 with `a_rvalid` one cycle after the A grant.
